// File: rtl/multi_seq_detect.sv
// multi_seq_detect: NCH independent serial pattern detectors.
// Each channel shifts its serial bit into a PAT_W-bit history on every
// en=1 cycle and emits a one-cycle registered pulse on z[k] when the newly
// accepted bit completes PATTERN (overlapping detection). A fill counter
// blocks matches until PAT_W samples have been accepted since reset.
//
// Optional feature: define SEQ_HIT_CNT_EN to build per-channel saturating
// hit counters (cleared by clr_cnt). Without it hit_cnt reads 0 and
// clr_cnt is ignored.
//
// Handshake: there is no valid/ready pair; en is a plain sample strobe,
// in is consumed on every rising edge where en=1, and nothing back-pressures.
module multi_seq_detect #(
  parameter int               NCH     = 4,
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter int               CNT_W   = 8,
  localparam int              SEL_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [NCH-1:0]   in,
  input  logic [SEL_W-1:0] sel,
  input  logic             clr_cnt,
  output logic [NCH-1:0]   z,
  output logic             out,
  output logic [CNT_W-1:0] hit_cnt,
  output logic             any_hit
);

  localparam int FILL_W = $clog2(PAT_W + 1);

  logic [PAT_W-1:0]  hist_q [NCH];
  logic [PAT_W-1:0]  hist_d [NCH];
  logic [FILL_W-1:0] fill_q [NCH];
  logic [FILL_W-1:0] fill_d [NCH];
  logic [NCH-1:0]    z_q;
  logic [NCH-1:0]    z_d;
  // The oldest history bit shifts out without being read by the comparator.
  logic [NCH-1:0]    hist_msb_unused;

  // Next history/fill per channel and the match that becomes z on the edge.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      hist_d[k]          = hist_q[k];
      fill_d[k]          = fill_q[k];
      z_d[k]             = 1'b0;
      hist_msb_unused[k] = hist_q[k][PAT_W-1];
      if (en) begin
        hist_d[k] = {hist_q[k][PAT_W-2:0], in[k]};
        if (fill_q[k] != FILL_W'(PAT_W)) begin
          fill_d[k] = fill_q[k] + FILL_W'(1);
        end
        // The sample being accepted now counts toward the PAT_W minimum.
        z_d[k] = (fill_q[k] >= FILL_W'(PAT_W - 1)) && (hist_d[k] == PATTERN);
      end
    end
  end

  // History, fill and match-pulse registers; reset discards partial history.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NCH; k++) begin
        hist_q[k] <= '0;
        fill_q[k] <= '0;
      end
      z_q <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        hist_q[k] <= hist_d[k];
        fill_q[k] <= fill_d[k];
      end
      z_q <= z_d;
    end
  end

`ifdef SEQ_HIT_CNT_EN
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_d [NCH];

  // Saturating hit counters; clear has priority over a same-edge increment.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      cnt_d[k] = cnt_q[k];
      if (clr_cnt) begin
        cnt_d[k] = '0;
      end else if (z_d[k] && (cnt_q[k] != {CNT_W{1'b1}})) begin
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NCH; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end
`else
  logic clr_cnt_unused;
  assign clr_cnt_unused = clr_cnt;
`endif

  // Channel-select mux; an out-of-range sel matches no channel and reads 0.
  always_comb begin
    out     = 1'b0;
    hit_cnt = '0;
    for (int k = 0; k < NCH; k++) begin
      if (sel == SEL_W'(k)) begin
        out = z_q[k];
`ifdef SEQ_HIT_CNT_EN
        hit_cnt = cnt_q[k];
`endif
      end
    end
  end

  assign z       = z_q;
  assign any_hit = |z_q;

endmodule

// File: tb/tb_multi_seq_detect.sv
// tb_multi_seq_detect: directed test of multi_seq_detect.
// u_dut uses default parameters; u_dut2 uses NCH=3, CNT_W=2 for the
// saturation and out-of-range select cases. Build with or without
// SEQ_HIT_CNT_EN; counter expectations follow the macro.
module tb_multi_seq_detect;

`ifdef SEQ_HIT_CNT_EN
  localparam bit HAS_CNT = 1'b1;
`else
  localparam bit HAS_CNT = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, clr_cnt;
  logic [3:0] din;
  logic [1:0] sel;
  logic [3:0] z;
  logic       out, any_hit;
  logic [7:0] hit_cnt;

  logic [2:0] din2;
  logic [1:0] sel2;
  logic       clr2;
  logic [2:0] z2;
  logic       out2, any2;
  logic [1:0] hit2;

  multi_seq_detect u_dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .in      (din),
    .sel     (sel),
    .clr_cnt (clr_cnt),
    .z       (z),
    .out     (out),
    .hit_cnt (hit_cnt),
    .any_hit (any_hit)
  );

  multi_seq_detect #(.NCH(3), .CNT_W(2)) u_dut2 (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .in      (din2),
    .sel     (sel2),
    .clr_cnt (clr2),
    .z       (z2),
    .out     (out2),
    .hit_cnt (hit2),
    .any_hit (any2)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    check("rst_z", z, 0);
    check("rst_any", any_hit, 0);
    check("rst_z2", z2, 0);
    rst = 1'b0;
  endtask

  // Feed bits[len-1] first into channel ch; exp_hit marks which samples
  // must produce the pulse on the following cycle.
  task automatic run_bits(input string tag, input int ch, input int len,
                          input logic [15:0] bits, input logic [15:0] exp_hit);
    logic [3:0] exp_z;
    for (int i = len - 1; i >= 0; i--) begin
      din     = 4'b0;
      din[ch] = bits[i];
      tick();
      exp_z = exp_hit[i] ? (4'b1 << ch) : 4'b0;
      check({tag, "_z"}, z, exp_z);
      check({tag, "_any"}, any_hit, exp_hit[i]);
      check({tag, "_out"}, out, exp_hit[i] && (int'(sel) == ch));
    end
    din = 4'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] s2, e2;
    int          cnt_exp;

    rst = 1'b1; en = 1'b0; clr_cnt = 1'b0; din = '0; sel = '0;
    din2 = '0; sel2 = '0; clr2 = 1'b0;
    tick();
    do_reset();
    check("rst_out", out, 0);
    check("rst_cnt", hit_cnt, 0);

    // Basic 1011 on channel 0, then a trailing 0 shows the pulse is single.
    en = 1'b1; sel = 2'd0;
    run_bits("basic", 0, 5, 16'b10110, 16'b00010);

    // Overlapping detection on channel 1.
    do_reset();
    sel = 2'd1;
    run_bits("ovl", 1, 7, 16'b1011011, 16'b0001001);
    check("ovl_cnt", hit_cnt, HAS_CNT ? 2 : 0);

    // en=0 gap holds history; in toggling is ignored meanwhile.
    do_reset();
    sel = 2'd2;
    run_bits("gap_a", 2, 2, 16'b10, 16'b00);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      din = (i % 2 == 0) ? 4'b1111 : 4'b0000;
      tick();
      check("gap_hold_z", z, 0);
    end
    en = 1'b1;
    run_bits("gap_b", 2, 2, 16'b11, 16'b01);

    // Mid-sequence reset discards partial history on channel 3.
    do_reset();
    sel = 2'd3;
    run_bits("pre_rst", 3, 3, 16'b101, 16'b000);
    do_reset();
    run_bits("post_rst1", 3, 1, 16'b1, 16'b0);
    run_bits("post_rst2", 3, 4, 16'b1011, 16'b0001);

    // All channels match simultaneously; sweep sel during the pulse.
    do_reset();
    begin
      logic [3:0] pat;
      pat = 4'b1011;
      for (int i = 3; i >= 0; i--) begin
        din = {4{pat[i]}};
        tick();
        check("all_z", z, (i == 0) ? 4'hF : 4'h0);
      end
      check("all_any", any_hit, 1);
      for (int s = 0; s < 4; s++) begin
        sel = 2'(s);
        #1;
        check("all_out", out, 1);
        check("all_cnt", hit_cnt, HAS_CNT ? 1 : 0);
      end
      din = '0;
      tick();
      check("all_after", z, 0);
    end

    // Narrow counter saturation on u_dut2 channel 0.
    do_reset();
    sel2 = 2'd0;
    s2 = 16'b1011011011011011;
    e2 = 16'b0001001001001001;
    cnt_exp = 0;
    for (int i = 15; i >= 0; i--) begin
      din2 = {2'b00, s2[i]};
      tick();
      check("sat_z", z2, {2'b00, e2[i]});
      if (e2[i]) begin
        cnt_exp = (cnt_exp < 3) ? cnt_exp + 1 : 3;
        check("sat_cnt", hit2, HAS_CNT ? cnt_exp : 0);
      end
    end
    check("sat_final", hit2, HAS_CNT ? 3 : 0);

    // Clear on the same edge a match completes: clear wins.
    din2 = 3'b000; tick();
    din2 = 3'b001; tick();
    din2 = 3'b001; clr2 = 1'b1; tick();
    clr2 = 1'b0;
    check("clr_z", z2, 3'b001);
    check("clr_cnt", hit2, 0);

    // Out-of-range select reads 0 while any_hit still pulses.
    sel2 = 2'd3;
    din2 = 3'b000; tick();
    din2 = 3'b001; tick();
    din2 = 3'b001; tick();
    check("oor_z", z2, 3'b001);
    check("oor_out", out2, 0);
    check("oor_cnt", hit2, 0);
    check("oor_any", any2, 1);
    sel2 = 2'd0;
    #1;
    check("inr_out", out2, 1);
    check("inr_cnt", hit2, HAS_CNT ? 1 : 0);
    din2 = '0;
    tick();
    check("oor_after", any2, 0);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_seq_detect.md
MULTI_SEQ_DETECT -- requirements
Module: multi_seq_detect

Interface
REQ-001 Parameter NCH, default 4: number of independent serial channels (1..16).
REQ-002 Parameter PAT_W, default 4: pattern length in bits (2..16).
REQ-003 Parameter PATTERN, default 4'b1011: target sequence; MSB is the oldest bit, LSB the newest.
REQ-004 Parameter CNT_W, default 8: width of each per-channel hit counter.
REQ-005 Port: clk, input, 1, the single clock; all logic SHALL be on its rising edge.
REQ-006 Port: rst, input, 1, reset; synchronous, active-high.
REQ-007 Port: en, input, 1, sample strobe; in is sampled only when en=1.
REQ-008 Port: in, input, NCH, serial bit per channel; bit k belongs to channel k.
REQ-009 Port: sel, input, max(1,$clog2(NCH)), channel select for out and hit_cnt.
REQ-010 Port: clr_cnt, input, 1, synchronous clear of all hit counters.
REQ-011 Port: z, output, NCH, per-channel registered match pulse.
REQ-012 Port: out, output, 1, z[sel].
REQ-013 Port: hit_cnt, output, CNT_W, hit counter of the channel selected by sel.
REQ-014 Port: any_hit, output, 1, OR of all z bits.

Function
REQ-015 Each channel SHALL keep a PAT_W-bit history shift register; on each en=1 cycle it shifts in in[k] at the LSB.
REQ-016 Each channel SHALL keep a fill counter; a match is permitted only after at least PAT_W samples have been accepted since reset.
REQ-017 z[k] SHALL be 1 in the cycle after the en=1 edge whose newly accepted bit completes history==PATTERN; latency is 1 clock from the sampling edge.
REQ-018 z[k] SHALL be a single-cycle pulse; it is 0 in every cycle not immediately following a completing en=1 sample.
REQ-019 With en=0, history and fill counter SHALL hold, and z SHALL be 0 on the next cycle.
REQ-020 Detection SHALL be overlapping: the bits ending one match may begin the next.
REQ-021 Channels SHALL be fully independent; simultaneous matches on several channels each assert their own z bit.
REQ-022 out and hit_cnt SHALL be combinational muxes of registered state indexed by sel.
REQ-023 When sel >= NCH, out and hit_cnt SHALL both be 0.
REQ-024 any_hit SHALL equal |z, combinational from registered z.

Reset
REQ-025 While rst=1 at a clock edge, all history registers, fill counters, z and hit counters SHALL clear to 0, overriding en and clr_cnt.
REQ-026 Asserting rst mid-sequence SHALL discard partial history; a full PAT_W samples are needed again before any match.
REQ-027 After reset, out=0, hit_cnt=0, any_hit=0, z=0.

Configuration
REQ-028 Macro SEQ_HIT_CNT_EN SHALL compile in the per-channel hit counters.
REQ-029 With SEQ_HIT_CNT_EN defined: counter k increments by 1 on each cycle z[k] is set, and saturates at 2^CNT_W-1 without wrapping.
REQ-030 With SEQ_HIT_CNT_EN defined: when clr_cnt=1, all counters become 0 on that edge, and clear wins over a simultaneous increment.
REQ-031 Without SEQ_HIT_CNT_EN: no counter registers exist, hit_cnt is tied to 0, and clr_cnt is ignored; all other behaviour is unchanged.

Verification
REQ-032 Defaults; en=1; in[0] driven 1,0,1,1 -> z[0]=1 exactly one cycle after the 4th bit; with sel=0, out=1 and any_hit=1 for that one cycle.
REQ-033 in[1] driven 1,0,1,1,0,1,1 with en=1 -> z[1] pulses twice, 3 cycles apart (overlap); with the macro, hit_cnt at sel=1 reads 2.
REQ-034 in[2] bits 1,0 with en=1, then en=0 for 5 cycles, then bits 1,1 with en=1 -> one z[2] pulse after the final bit, and z[2]=0 throughout the en=0 gap.
REQ-035 rst pulsed after in[3] bits 1,0,1; then a single bit 1 -> no match; then 1,0,1,1 -> match.
REQ-036 CNT_W=2 with the macro: 5 matches on channel 0 -> hit_cnt=3; clr_cnt asserted on the same edge a match completes -> hit_cnt=0.
REQ-037 NCH=3, sel=3 while channel matches occur -> out=0 and hit_cnt=0; any_hit still pulses.
